// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the execute
// datapath, instruction memory and data memory.
interface multicycle_ctrl_if #(
  parameter int RET_W = 32
);
  logic             halt;
  logic [3:0]       instr_op;
  logic             zero;
  logic             i_ready;
  logic             d_ready;
  logic             i_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       PC_Src;
  logic [1:0]       ALUSrc;
  logic [3:0]       ALUOp;
  logic             mem_R;
  logic             mem_W;
  logic             WB;
  logic             RegW;
  logic             link;
  logic             flags_write;
  logic [2:0]       state;
  logic             fault;
  logic [RET_W-1:0] retired;

  modport master (
    input  halt, instr_op, zero, i_ready, d_ready,
    output i_req, ir_write, pc_write, PC_Src, ALUSrc, ALUOp, mem_R, mem_W,
           WB, RegW, link, flags_write, state, fault, retired
  );

  modport slave (
    output halt, instr_op, zero, i_ready, d_ready,
    input  i_req, ir_write, pc_write, PC_Src, ALUSrc, ALUOp, mem_R, mem_W,
           WB, RegW, link, flags_write, state, fault, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// memory-ready handshakes, a wait timeout, a retired counter and a sticky FAULT state.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_W       = 32
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = {WAIT_W{1'b1}};

  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_ANDI = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;
  localparam logic [3:0] OP_JAL  = 4'd10;
  localparam logic [3:0] OP_SLL  = 4'd11;
  localparam logic [3:0] OP_SLR  = 4'd12;
  localparam logic [3:0] OP_ILL  = 4'd15;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [RET_W-1:0] retired_q, retired_d;

  logic       timeout_s;
  logic       waiting_s;
  logic       retire_s;
  logic       i_req_s, ir_write_s, pc_write_s;
  logic [1:0] pc_src_s, alu_src_s;
  logic [3:0] alu_op_s;
  logic       mem_r_s, mem_w_s, wb_s, reg_w_s, link_s, flags_write_s;

  // Immediate-type and shift-amount operand selection for the ALU B input.
  function automatic logic [1:0] alu_src_f(input logic [3:0] op);
    logic [1:0] src;
    case (op)
      OP_ANDI, OP_ADDI, OP_LW, OP_SW: src = 2'b01;
      OP_SLL, OP_SLR:                 src = 2'b10;
      default:                        src = 2'b00;
    endcase
    return src;
  endfunction

  assign timeout_s = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);
  assign waiting_s = ((state_q == ST_FETCH) && !bus.i_ready) ||
                     ((state_q == ST_MEMORY) && !bus.d_ready);

  // State, opcode, wait counter and retired counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'd0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    wait_d        = wait_q;
    retired_d     = retired_q;
    retire_s      = 1'b0;
    i_req_s       = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    pc_src_s      = PC_SEQ;
    alu_src_s     = 2'b00;
    alu_op_s      = 4'd0;
    mem_r_s       = 1'b0;
    mem_w_s       = 1'b0;
    wb_s          = 1'b0;
    reg_w_s       = 1'b0;
    link_s        = 1'b0;
    flags_write_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.halt) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.i_ready) begin
          i_req_s    = 1'b1;
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          pc_src_s   = PC_SEQ;
          op_d       = bus.instr_op;
          state_d    = ST_DECODE;
        end else if (timeout_s) begin
          state_d = ST_FAULT;
        end else begin
          i_req_s = 1'b1;
        end
      end
      ST_DECODE: begin
        case (op_q)
          OP_ILL: state_d = ST_FAULT;
          OP_J: begin
            pc_write_s = 1'b1;
            pc_src_s   = PC_JUMP;
            retire_s   = 1'b1;
          end
          OP_JAL: begin
            pc_write_s = 1'b1;
            pc_src_s   = PC_JUMP;
            reg_w_s    = 1'b1;
            link_s     = 1'b1;
            retire_s   = 1'b1;
          end
          default: state_d = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        alu_op_s  = op_q;
        alu_src_s = alu_src_f(op_q);
        case (op_q)
          OP_BEQ: begin
            pc_write_s = bus.zero;
            pc_src_s   = PC_BRANCH;
            retire_s   = 1'b1;
          end
          OP_CMP: begin
            flags_write_s = 1'b1;
            retire_s      = 1'b1;
          end
          OP_LW, OP_SW: state_d = ST_MEMORY;
          default:      state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        alu_op_s  = op_q;
        alu_src_s = alu_src_f(op_q);
        // Strobes drop in the cycle a timeout hands over to FAULT.
        if (bus.d_ready) begin
          mem_r_s = (op_q == OP_LW);
          mem_w_s = (op_q == OP_SW);
          if (op_q == OP_SW) begin
            retire_s = 1'b1;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (timeout_s) begin
          state_d = ST_FAULT;
        end else begin
          mem_r_s = (op_q == OP_LW);
          mem_w_s = (op_q == OP_SW);
        end
      end
      ST_WRITEBACK: begin
        reg_w_s  = 1'b1;
        wb_s     = (op_q == OP_LW);
        retire_s = 1'b1;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    if (retire_s) begin
      retired_d = retired_q + RET_W'(1);
      state_d   = bus.halt ? ST_IDLE : ST_FETCH;
    end else begin
      retired_d = retired_q;
    end

    if ((state_d != state_q) || !waiting_s) begin
      wait_d = '0;
    end else if (wait_q != WAIT_SAT) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  assign bus.i_req       = i_req_s;
  assign bus.ir_write    = ir_write_s;
  assign bus.pc_write    = pc_write_s;
  assign bus.PC_Src      = pc_src_s;
  assign bus.ALUSrc      = alu_src_s;
  assign bus.ALUOp       = alu_op_s;
  assign bus.mem_R       = mem_r_s;
  assign bus.mem_W       = mem_w_s;
  assign bus.WB          = wb_s;
  assign bus.RegW        = reg_w_s;
  assign bus.link        = link_s;
  assign bus.flags_write = flags_write_s;
  assign bus.state       = state_q;
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: expected per-cycle control traces are
// built per instruction from the opcode rules, then compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.RET_W(3)) bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .RET_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       i_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pcs;
    logic [1:0] alus;
    logic [3:0] aluop;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic       rw;
    logic       lk;
    logic       fw;
  } ctl_t;

  typedef struct packed {
    logic ir;
    logic dr;
    logic acc;
  } stim_t;

  int total = 0;
  int bad = 0;
  logic [2:0] ret_m;

  function automatic ctl_t blank(input logic [2:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic logic [1:0] src_of(input logic [3:0] op);
    if (op >= 4'd4 && op <= 4'd7) return 2'b01;
    if (op == 4'd11 || op == 4'd12) return 2'b10;
    return 2'b00;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.st = bus.state;       c.i_req = bus.i_req;   c.ir_write = bus.ir_write;
    c.pc_write = bus.pc_write; c.pcs = bus.PC_Src; c.alus = bus.ALUSrc;
    c.aluop = bus.ALUOp;    c.mem_r = bus.mem_R;   c.mem_w = bus.mem_W;
    c.wb = bus.WB;          c.rw = bus.RegW;       c.lk = bus.link;
    c.fw = bus.flags_write;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.halt = 1'b1;
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_retired", 32'(bus.retired), 32'd0);
    check("rst_ctl", {12'd0, observe()}, {12'd0, blank(3'd0)});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_halt", 32'(bus.state), 32'd0);
    @(negedge clk);
    bus.halt = 1'b0;
    #1;
    check("idle_ctl", {12'd0, observe()}, {12'd0, blank(3'd0)});
    @(posedge clk);
    #1;
    check("idle_to_fetch", 32'(bus.state), 32'd1);
    ret_m = 3'd0;
  endtask

  // fw/mw: cycles with ready low before it rises; TO or more means a timeout.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                           input logic zv, input logic hv);
    ctl_t  eq[$];
    stim_t sq[$];
    ctl_t  e;
    stim_t s;
    logic  flt;
    logic [3:0] nop;
    flt = 1'b0;
    for (int k = 0; k < fw && k < TO; k++) begin
      e = blank(3'd1); e.i_req = (k < TO - 1); eq.push_back(e);
      s = '0; s.dr = 1'($urandom); sq.push_back(s);
    end
    if (fw >= TO) begin
      flt = 1'b1;
    end else begin
      e = blank(3'd1); e.i_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
      eq.push_back(e);
      s = '0; s.ir = 1'b1; s.dr = 1'($urandom); s.acc = 1'b1; sq.push_back(s);
      e = blank(3'd2);
      if (op == 4'd9 || op == 4'd10) begin
        e.pc_write = 1'b1; e.pcs = 2'b01; e.rw = (op == 4'd10); e.lk = (op == 4'd10);
      end
      eq.push_back(e);
      s = '0; s.ir = 1'($urandom); s.dr = 1'($urandom); sq.push_back(s);
      if (op == 4'd15) begin
        flt = 1'b1;
      end else if (op != 4'd9 && op != 4'd10) begin
        e = blank(3'd3); e.aluop = op; e.alus = src_of(op);
        if (op == 4'd8) begin e.pc_write = zv; e.pcs = 2'b10; end
        if (op == 4'd3) e.fw = 1'b1;
        eq.push_back(e);
        s = '0; s.ir = 1'($urandom); s.dr = 1'($urandom); sq.push_back(s);
        if (op == 4'd6 || op == 4'd7) begin
          for (int k = 0; k < mw && k < TO; k++) begin
            e = blank(3'd4); e.aluop = op; e.alus = 2'b01;
            e.mem_r = (op == 4'd6) && (k < TO - 1);
            e.mem_w = (op == 4'd7) && (k < TO - 1);
            eq.push_back(e);
            s = '0; s.ir = 1'($urandom); sq.push_back(s);
          end
          if (mw >= TO) begin
            flt = 1'b1;
          end else begin
            e = blank(3'd4); e.aluop = op; e.alus = 2'b01;
            e.mem_r = (op == 4'd6); e.mem_w = (op == 4'd7);
            eq.push_back(e);
            s = '0; s.ir = 1'($urandom); s.dr = 1'b1; sq.push_back(s);
          end
        end
        if (!flt && op != 4'd3 && op != 4'd7 && op != 4'd8) begin
          e = blank(3'd5); e.rw = 1'b1; e.wb = (op == 4'd6); eq.push_back(e);
          s = '0; s.ir = 1'($urandom); s.dr = 1'($urandom); sq.push_back(s);
        end
      end
    end

    foreach (eq[i]) begin
      @(negedge clk);
      bus.i_ready = sq[i].ir;
      bus.d_ready = sq[i].dr;
      bus.zero = zv;
      bus.halt = hv;
      nop = 4'($urandom);
      bus.instr_op = sq[i].acc ? op : nop;
      #1;
      check($sformatf("op%0d_cyc%0d", op, i), {12'd0, observe()}, {12'd0, eq[i]});
    end
    @(posedge clk);
    #1;
    if (flt) begin
      check("fault_state", 32'(bus.state), 32'd7);
      check("fault_flag", 32'(bus.fault), 32'd1);
      check("fault_keeps_retired", 32'(bus.retired), 32'(ret_m));
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        bus.halt = 1'($urandom);
        bus.i_ready = 1'b1;
        bus.d_ready = 1'b1;
        #1;
        check("fault_sticky_ctl", {12'd0, observe()}, {12'd0, blank(3'd7)});
        check("fault_sticky_flag", 32'(bus.fault), 32'd1);
      end
    end else begin
      ret_m = ret_m + 3'd1;
      check($sformatf("retired_op%0d", op), 32'(bus.retired), 32'(ret_m));
      check($sformatf("after_op%0d_state", op), 32'(bus.state), hv ? 32'd0 : 32'd1);
      if (hv) begin
        @(negedge clk);
        bus.halt = 1'b0;
        #1;
        check("halt_idle_ctl", {12'd0, observe()}, {12'd0, blank(3'd0)});
        @(posedge clk);
        #1;
        check("halt_resume", 32'(bus.state), 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.halt = 1'b0;
    bus.instr_op = 4'd0;
    bus.zero = 1'b0;
    bus.i_ready = 1'b1;
    bus.d_ready = 1'b1;
    ret_m = 3'd0;
    #1;
    check("por_state", 32'(bus.state), 32'd0);
    check("por_ctl", {12'd0, observe()}, {12'd0, blank(3'd0)});
    do_reset();

    // ADD, LW, SW, taken BEQ, J with zero-wait memories
    run_instr(4'd1, 0, 0, 1'b0, 1'b0);
    run_instr(4'd6, 0, 0, 1'b0, 1'b0);
    run_instr(4'd7, 0, 0, 1'b0, 1'b0);
    run_instr(4'd8, 0, 0, 1'b1, 1'b0);
    run_instr(4'd9, 0, 0, 1'b0, 1'b0);
    check("five_retired", 32'(bus.retired), 32'd5);

    run_instr(4'd8, 0, 0, 1'b0, 1'b0);
    run_instr(4'd6, 0, 3, 1'b0, 1'b0);
    run_instr(4'd7, 0, 2, 1'b0, 1'b1);
    run_instr(4'd1, 3, 0, 1'b0, 1'b0);
    run_instr(4'd10, 0, 0, 1'b0, 1'b0);
    run_instr(4'd3, 1, 0, 1'b1, 1'b0);
    run_instr(4'd11, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      run_instr(4'($urandom_range(14, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), 1'($urandom),
                ($urandom_range(3, 0) == 0));
    end

    run_instr(4'd15, 0, 0, 1'b0, 1'b0);
    do_reset();
    run_instr(4'd1, TO, 0, 1'b0, 1'b0);
    do_reset();
    run_instr(4'd6, 1, TO, 1'b0, 1'b0);
    do_reset();

    for (int n = 0; n < 8; n++) begin
      run_instr(4'd9, 0, 0, 1'b0, 1'b0);
    end
    check("retired_wrap", 32'(bus.retired), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the execute datapath: ALU, 3:1 ALU-source mux, branch adder and PC-source select. It walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. In each state it drives ALUOp, ALUSrc, PC_Src, memory-strobe and write-back controls, and it waits on instruction-memory and data-memory ready handshakes. It also counts retired instructions and latches a sticky fault on an illegal opcode or a memory timeout.

Parameters:
MEM_TIMEOUT, 15, max consecutive wait cycles on i_ready/d_ready before FAULT; 0 disables the timeout.
RET_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset.
halt  in  1  when 1, the block parks in IDLE at the next instruction boundary.
instr_op  in  4  opcode from the fetch bus; captured on the cycle i_ready is accepted in FETCH.
zero  in  1  ALU zero flag; used only in EXECUTE for BEQ.
i_ready  in  1  instruction memory has data this cycle.
d_ready  in  1  data memory has completed the access this cycle.
i_req  out  1  instruction fetch request.
ir_write  out  1  load the instruction register.
pc_write  out  1  update PC from the PC_Src selection.
PC_Src  out  2  00 = PC+4, 01 = jump target, 10 = branch target.
ALUSrc  out  2  00 = register Op2, 01 = ExImm, 10 = SA.
ALUOp  out  4  ALU operation.
mem_R  out  1  data read strobe.
mem_W  out  1  data write strobe.
WB  out  1  write-back select: 1 = memory data, 0 = ALU result.
RegW  out  1  register file write enable.
link  out  1  write-back of PC to R31 (JAL).
flags_write  out  1  latch the ALU flags (CMP).
state  out  3  IDLE = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, MEMORY = 4, WRITEBACK = 5, FAULT = 7.
fault  out  1  sticky error indication.
retired  out  RET_W  count of retired instructions.

Behaviour:
General rules
- Reset (rst = 0, asynchronous): state = IDLE, op_q = 0, wait counter = 0, retired = 0, fault = 0. All control outputs are 0 while in reset.
- Outputs are a Moore decode of state and op_q, except the BEQ pc_write and every handshake-qualified strobe noted below.
- Opcode map (op_q):
  - 0 AND, 1 ADD, 2 SUB, 3 CMP, 4 ANDI, 5 ADDI, 6 LW, 7 SW
  - 8 BEQ, 9 J, 10 JAL, 11 SLL, 12 SLR, 13 SLLV, 14 SLRV, 15 illegal
- ALUOp = op_q in EXECUTE and MEMORY; 0 in all other states.
- ALUSrc in EXECUTE/MEMORY: 01 for opcodes 4–7; 10 for opcodes 11–12; 00 otherwise.

State sequence
- IDLE: all outputs 0. Go to FETCH when halt = 0.
- FETCH: i_req = 1.
  - When i_ready = 1: ir_write = 1, pc_write = 1, PC_Src = 00, op_q <= instr_op, go to DECODE.
  - i_ready is honoured in the first FETCH cycle.
- DECODE (1 cycle):
  - op 15: go to FAULT.
  - J: pc_write = 1, PC_Src = 01, retire.
  - JAL: pc_write = 1, PC_Src = 01, RegW = 1, link = 1, retire.
  - Otherwise: go to EXECUTE.
- EXECUTE (1 cycle):
  - BEQ: pc_write = zero, PC_Src = 10, retire.
  - CMP: flags_write = 1, retire.
  - LW/SW: go to MEMORY.
  - Others: go to WRITEBACK.
- MEMORY: mem_R = 1 (LW) or mem_W = 1 (SW); ALUOp/ALUSrc held stable.
  - On d_ready = 1: SW retires; LW goes to WRITEBACK.
- WRITEBACK (1 cycle): RegW = 1; WB = 1 for LW, 0 otherwise; retire.
- Retire:
  - retired increments by 1, wrapping modulo 2^RET_W.
  - Next state is IDLE if halt = 1, else FETCH. halt is never honoured mid-instruction.
- FAULT: fault = 1; all other controls 0; stays in FAULT until reset. halt has no effect in FAULT.

Wait counter
- Counts consecutive FETCH/MEMORY cycles with the relevant ready signal low; cleared on ready and on every state change.
- If it reaches MEM_TIMEOUT (MEM_TIMEOUT != 0), go to FAULT. No strobe is issued in the transition cycle.
- A ready signal in the same cycle the count reaches MEM_TIMEOUT wins: normal progress, no fault.

Latency (zero-wait memory, excluding IDLE)
- J/JAL: 2 cycles.
- BEQ/CMP: 3 cycles.
- SW and ALU ops: 4 cycles.
- LW: 5 cycles.

Reset mid-instruction
- Aborts immediately; no partial retire. The block restarts in IDLE.

Test Plan:
- Reset, halt = 0, i_ready/d_ready tied to 1, instruction stream ADD, LW, SW, BEQ (zero = 1), J -> state trace 1,2,3,5 / 1,2,3,4,5 / 1,2,3,4 / 1,2,3 / 1,2. retired = 5 after 18 cycles in FETCH onward. ALUSrc is 00,01,01,00 in EXECUTE. BEQ pc_write = 1 with PC_Src = 10.
- BEQ with zero = 0 -> no pc_write in EXECUTE; retired still increments by 1; next state FETCH.
- LW with d_ready low for 3 cycles -> mem_R = 1 and ALUOp = 6 held for 4 cycles; WRITEBACK asserts WB = 1 and RegW = 1.
- MEM_TIMEOUT = 4, i_ready held 0 -> FAULT after 4 FETCH cycles; fault = 1 sticky. Asserting rst = 0 for 1 cycle returns state = 0 with fault = 0.
- instr_op = 15 -> DECODE then FAULT; retired unchanged; no RegW/pc_write after the FETCH pc_write.
- halt = 1 asserted during MEMORY of an SW -> SW completes and retires, then state = IDLE. Deassert halt -> FETCH next cycle. Separately, with RET_W = 3, 8 J instructions -> retired wraps to 0.
